// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// The divide-by-zero quotient is stored at full width and sliced by each user.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MAX_WIDTH = 32;

    // All-ones quotient reported on divide-by-zero
    localparam logic [MAX_WIDTH-1:0] DIV0_QUOT = '1;

endpackage

// File: rtl/div_step.sv
// One combinational radix-2 restoring division step.
// The caller supplies the partial remainder already shifted left with the next dividend bit.
module div_step #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH:0]   part,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem,
    output logic             q_bit
);

    logic [WIDTH:0] diff;

    // part < 2*divisor always holds, so a non-negative difference fits in WIDTH bits
    always_comb begin
        diff  = part - {1'b0, divisor};
        q_bit = ~diff[WIDTH];
        rem   = q_bit ? diff[WIDTH-1:0] : part[WIDTH-1:0];
    end

endmodule

// File: rtl/div_seq_param.sv
// Sequential restoring divider: one quotient bit per clock, WIDTH+1 cycles per division.
// Define DIV_SIGNED_EN for two's-complement operands (magnitude divide plus sign fix-up).
module div_seq_param
    import div_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             res,
    input  logic             load,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] reminder,
    output logic             error,
    output logic             busy,
    output logic             done
);

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] dvd_reg;   // dividend bits shift out the top, quotient bits in the bottom
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] dvs_reg;

    logic [WIDTH:0]   step_part;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;
    logic [WIDTH-1:0] quot_next;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

`ifdef DIV_SIGNED_EN
    logic neg_q_reg;
    logic neg_r_reg;
`endif

    assign step_part = {rem_reg, dvd_reg[WIDTH-1]};
    assign quot_next = {dvd_reg[WIDTH-2:0], step_q};

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .part    (step_part),
        .divisor (dvs_reg),
        .rem     (step_rem),
        .q_bit   (step_q)
    );

`ifdef DIV_SIGNED_EN
    // Magnitude of the most negative value is its own bit pattern read as unsigned
    always_comb begin
        mag_a    = A[WIDTH-1] ? (~A + 1'b1) : A;
        mag_b    = B[WIDTH-1] ? (~B + 1'b1) : B;
        quot_fix = neg_q_reg ? (~quot_next + 1'b1) : quot_next;
        rem_fix  = neg_r_reg ? (~step_rem + 1'b1) : step_rem;
    end
`else
    always_comb begin
        mag_a    = A;
        mag_b    = B;
        quot_fix = quot_next;
        rem_fix  = step_rem;
    end
`endif

    always_ff @(posedge clk) begin
        if (!res) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            dvd_reg   <= '0;
            rem_reg   <= '0;
            dvs_reg   <= '0;
            quotient  <= '0;
            reminder  <= '0;
            error     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    done <= 1'b0;
                    if (load) begin
                        busy <= 1'b1;
                        if (B == '0) begin
                            state_reg <= DONE;
                            quotient  <= DIV0_QUOT[WIDTH-1:0];
                            reminder  <= A;
                            error     <= 1'b1;
                            done      <= 1'b1;
                        end else begin
                            state_reg <= CALC;
                            cnt_reg   <= CNT_W'(WIDTH);
                            dvd_reg   <= mag_a;
                            dvs_reg   <= mag_b;
                            rem_reg   <= '0;
`ifdef DIV_SIGNED_EN
                            neg_q_reg <= A[WIDTH-1] ^ B[WIDTH-1];
                            neg_r_reg <= A[WIDTH-1];
`endif
                        end
                    end
                end
                CALC: begin
                    dvd_reg <= quot_next;
                    rem_reg <= step_rem;
                    cnt_reg <= cnt_reg - CNT_W'(1);
                    // Final step: register the finished result straight from the step outputs
                    if (cnt_reg == CNT_W'(1)) begin
                        state_reg <= DONE;
                        quotient  <= quot_fix;
                        reminder  <= rem_fix;
                        error     <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_param.sv
// Randomized self-checking bench for div_seq_param against a cycle-level arithmetic model.
module tb_div_seq_param;

    localparam int W = 5;

    logic         clk;
    logic         res;
    logic         load;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] quotient;
    logic [W-1:0] reminder;
    logic         error;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;

    div_seq_param #(.WIDTH(W)) dut (
        .clk      (clk),
        .res      (res),
        .load     (load),
        .A        (A),
        .B        (B),
        .quotient (quotient),
        .reminder (reminder),
        .error    (error),
        .busy     (busy),
        .done     (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                      output logic [W-1:0] q, output logic [W-1:0] r,
                                      output logic e);
        if (b == '0) begin
            q = '1;
            r = a;
            e = 1'b1;
        end else begin
`ifdef DIV_SIGNED_EN
            int sa;
            int sb;
            sa = $signed(a);
            sb = $signed(b);
            q  = W'(sa / sb);
            r  = W'(sa % sb);
`else
            q = a / b;
            r = a % b;
`endif
            e = 1'b0;
        end
    endfunction

    // Model: edges are numbered; an accepted load at edge p finishes at edge d
    int           edge_n     = 0;
    int           busy_until = -5;
    int           done_edge  = -5;
    logic [W-1:0] pq, pr, mq, mr;
    logic         pe, me;
    logic         exp_busy, exp_done;
    bit           started    = 0;

    always @(posedge clk) begin
        edge_n++;
        if (!res) begin
            mq = '0; mr = '0; me = 1'b0;
            busy_until = -5;
            done_edge  = -5;
        end else begin
            if (load && edge_n > busy_until + 1) begin
                model_div(A, B, pq, pr, pe);
                done_edge  = edge_n + ((B == '0) ? 0 : W);
                busy_until = done_edge;
            end
            if (edge_n == done_edge) begin
                mq = pq; mr = pr; me = pe;
            end
        end
        exp_busy = (edge_n <= busy_until);
        exp_done = (edge_n == done_edge);
    end

    always @(negedge clk) begin
        if (started) begin
            chk("done", done, exp_done);
            chk("busy", busy, exp_busy);
            chk("quotient", quotient, mq);
            chk("reminder", reminder, mr);
            chk("error", error, me);
        end
    end

    // Starts and returns at a negedge while the DUT is idle
    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                      output int lat, output logic [W-1:0] q, output logic [W-1:0] r,
                      output logic e);
        A = a; B = b; load = 1'b1;
        lat = -1;
        q = '0; r = '0; e = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k >= hold) load = 1'b0;
            A = W'($urandom);
            B = W'($urandom);
            if (done) begin
                lat = k;
                q = quotient; r = reminder; e = error;
                load = 1'b0;
                break;
            end
        end
        if (lat < 0) chk("done_timeout", 32'(lat), 32'd0);
        @(negedge clk);
    endtask

    int           lat;
    logic [W-1:0] q, r;
    logic         e;

    initial begin
        res = 1'b0; load = 1'b0; A = '0; B = '0;
        repeat (2) @(negedge clk);
        started = 1;
        chk("reset_quotient", quotient, 0);
        chk("reset_busy", busy, 0);
        res = 1'b1;
        @(negedge clk);

`ifdef DIV_SIGNED_EN
        op(5'b11001, 5'd2, 1, lat, q, r, e);
        chk("lat_m7_2", lat, W + 1);
        chk("q_m7_2", q, 5'b11101);
        chk("r_m7_2", r, 5'b11111);
        chk("model_q_m7_2", mq, 5'b11101);
        op(5'b10000, 5'b11111, 1, lat, q, r, e);
        chk("q_min_m1", q, 5'b10000);
        chk("r_min_m1", r, 0);
        chk("e_min_m1", e, 0);
        op(5'b10101, 5'd0, 1, lat, q, r, e);
        chk("lat_div0", lat, 1);
        chk("q_div0", q, 31);
        chk("r_div0", r, 5'b10101);
        chk("e_div0", e, 1);
`else
        op(5'd29, 5'd14, 1, lat, q, r, e);
        chk("lat_29_14", lat, 6);
        chk("q_29_14", q, 2);
        chk("r_29_14", r, 1);
        chk("e_29_14", e, 0);
        chk("model_q_29_14", mq, 2);
        op(5'd10, 5'd26, 1, lat, q, r, e);
        chk("q_10_26", q, 0);
        chk("r_10_26", r, 10);
        op(5'd0, 5'd26, 1, lat, q, r, e);
        chk("q_0_26", q, 0);
        chk("r_0_26", r, 0);
        op(5'd21, 5'd0, 1, lat, q, r, e);
        chk("lat_21_0", lat, 1);
        chk("q_21_0", q, 31);
        chk("r_21_0", r, 21);
        chk("e_21_0", e, 1);
        chk("model_r_21_0", mr, 21);
        op(5'd29, 5'd3, 1, lat, q, r, e);
        chk("q_29_3", q, 9);
        chk("r_29_3", r, 2);
        chk("e_29_3", e, 0);
        op(5'd31, 5'd1, 5, lat, q, r, e);
        chk("lat_hold5", lat, 6);
        chk("q_hold5", q, 31);
        chk("r_hold5", r, 0);
`endif

        // Reset during the third CALC cycle aborts without a done pulse
        A = 5'd29; B = 5'd3; load = 1'b1;
        @(negedge clk); load = 1'b0;
        @(negedge clk);
        @(negedge clk); res = 1'b0;
        @(negedge clk);
        chk("abort_quotient", quotient, 0);
        chk("abort_reminder", reminder, 0);
        chk("abort_error", error, 0);
        chk("abort_busy", busy, 0);
        res = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
        end

        for (int n = 0; n < 200; n++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            op(ra, rb, $urandom_range(1, W), lat, q, r, e);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
